// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte-addressed load/store controller in front of a 64x32 async-read RAM.
// Define MEM_PERF_CNT_EN to add the LoadCnt/StoreCnt completion counters.
module mem_access_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic              IsStore,
  input  logic [1:0]        Size,
  input  logic              Signed,
  input  logic [ADDR_W+1:0] ByteAddr,
  input  logic [31:0]       WData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [31:0]       RData,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemD,
  input  logic [31:0]       MemSPO
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       LoadCnt,
  output logic [31:0]       StoreCnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic        st_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        misaligned;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [31:0] merge_v;

  assign misaligned = (Size == 2'b11)
                    | ((Size == 2'b01) & ByteAddr[0])
                    | ((Size == 2'b10) & (ByteAddr[1:0] != 2'b00));

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = (state != S_IDLE);
    Done      = 1'b0;
    Err       = 1'b0;
    case (state)
      S_IDLE:   if (Req) state_nxt = misaligned ? S_ERR : S_ACCESS;
      S_ACCESS: state_nxt = (st_q && size_q != 2'b10) ? S_WRITE : S_DONE;
      S_WRITE:  state_nxt = S_DONE;
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        Done      = 1'b1;
        Err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, both off the live read word.
  always_comb begin
    byte_sh = {lane_q, 3'b000};
    half_sh = {lane_q[1], 4'b0000};
    byte_v  = MemSPO[byte_sh +: 8];
    half_v  = MemSPO[half_sh +: 16];
    case (size_q)
      2'b00:   load_v = {{24{sgn_q & byte_v[7]}}, byte_v};
      2'b01:   load_v = {{16{sgn_q & half_v[15]}}, half_v};
      default: load_v = MemSPO;
    endcase
    merge_v = MemSPO;
    if (size_q == 2'b00) merge_v[byte_sh +: 8]  = wdata_q[7:0];
    else                 merge_v[half_sh +: 16] = wdata_q[15:0];
  end

  // Memory port is registered: a word store raises MemWE for the ACCESS cycle,
  // a sub-word store raises it for the WRITE cycle with MemD doubling as the merge register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      lane_q  <= 2'b00;
      wdata_q <= 16'h0;
      RData   <= 32'h0;
      MemWE   <= 1'b0;
      MemAddr <= '0;
      MemD    <= 32'h0;
    end else begin
      MemWE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            st_q    <= IsStore;
            size_q  <= Size;
            sgn_q   <= Signed;
            lane_q  <= ByteAddr[1:0];
            wdata_q <= WData[15:0];
            if (!misaligned) begin
              MemAddr <= ByteAddr[ADDR_W+1:2];
              if (IsStore && Size == 2'b10) begin
                MemWE <= 1'b1;
                MemD  <= WData;
              end
            end
          end
        end
        S_ACCESS: begin
          if (!st_q) begin
            RData <= load_v;
          end else if (size_q != 2'b10) begin
            MemWE <= 1'b1;
            MemD  <= merge_v;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      LoadCnt  <= 32'h0;
      StoreCnt <= 32'h0;
    end else if (state == S_DONE) begin
      if (st_q) StoreCnt <= StoreCnt + 32'd1;
      else      LoadCnt  <= LoadCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench for mem_access_ctrl with a word-array reference model.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req = 1'b0;
  logic        IsStore = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Signed = 1'b0;
  logic [7:0]  ByteAddr = 8'h0;
  logic [31:0] WData = 32'h0;
  logic        Busy, Done, Err, MemWE;
  logic [31:0] RData, MemD, MemSPO;
  logic [5:0]  MemAddr;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] LoadCnt, StoreCnt;
`endif

  mem_access_ctrl #(.ADDR_W(6)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .IsStore(IsStore), .Size(Size), .Signed(Signed),
    .ByteAddr(ByteAddr), .WData(WData), .Busy(Busy), .Done(Done), .Err(Err), .RData(RData),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemD(MemD), .MemSPO(MemSPO)
`ifdef MEM_PERF_CNT_EN
    , .LoadCnt(LoadCnt), .StoreCnt(StoreCnt)
`endif
  );

  always #5 Clk = ~Clk;

  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rdata;
  logic        ram_loaded = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;

  assign MemSPO = ram[MemAddr];

  always @(posedge Clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 64; i++) ram[i] <= ref_mem[i];
      ram_loaded <= 1'b1;
    end else if (MemWE) begin
      ram[MemAddr] <= MemD;
    end
  end

  // Reference: word array plus shift/mask arithmetic on the byte address.
  task automatic model_op(input bit st, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                          input logic [31:0] wd, output int lat, output bit err,
                          output logic [31:0] rd, output int we);
    int wi, ln;
    logic [31:0] w, v, mask;
    wi   = a / 4;
    ln   = a % 4;
    w    = ref_mem[wi];
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    err  = (sz == 3) || (sz == 1 && ln % 2 == 1) || (sz == 2 && ln != 0);
    we   = 0;
    if (err) begin
      lat = 1;
    end else if (!st) begin
      lat = 2;
      v = (w >> (8 * ln)) & mask;
      if (sg && sz != 2 && v > (mask >> 1)) v = v | ~mask;
      ref_rdata = v;
    end else begin
      lat = (sz == 2) ? 2 : 3;
      we  = 1;
      ref_mem[wi] = (w & ~(mask << (8 * ln))) | ((wd & mask) << (8 * ln));
    end
    rd = ref_rdata;
  endtask

  task automatic run_op(input bit st, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                        input logic [31:0] wd, output int lat, output bit err,
                        output logic [31:0] rd, output int we_cnt,
                        output logic [5:0] we_addr, output logic [31:0] we_data);
    @(negedge Clk);
    Req = 1'b1; IsStore = st; Size = sz; Signed = sg; ByteAddr = a; WData = wd;
    @(posedge Clk);
    #1;
    Req = 1'b0; IsStore = $urandom_range(0, 1); Size = 2'($urandom_range(0, 3));
    Signed = $urandom_range(0, 1); ByteAddr = 8'($urandom); WData = $urandom;
    lat = -1; err = 1'b0; rd = 32'h0; we_cnt = 0; we_addr = 6'h0; we_data = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (MemWE) begin
        we_cnt++; we_addr = MemAddr; we_data = MemD;
      end
      if (Done) begin
        lat = k; err = Err; rd = RData;
        break;
      end
    end
    @(negedge Clk);
    if (MemWE) we_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({Busy, Done, Err, MemWE, RData, MemAddr, MemD} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {Busy, Done, Err, MemWE, RData, MemAddr, MemD});
    end
    Rst = 1'b0;
    ref_rdata = 32'h0;
    @(negedge Clk);
    n_cmp++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b exp=0", Busy); end
  endtask

`ifdef MEM_PERF_CNT_EN
  task automatic test_perf_cnt();
    int el, gl, ew, gw; bit ee, ge; logic [31:0] er, gr, wdt; logic [5:0] wa;
    for (int i = 0; i < 6; i++) begin
      bit st; logic [1:0] sz; logic [7:0] a;
      st = (i == 1 || i == 3);
      sz = (i == 5) ? 2'b10 : 2'($urandom_range(0, 2));
      a  = 8'($urandom) & ((sz == 2) ? 8'hFC : (sz == 1) ? 8'hFE : 8'hFF);
      if (i == 5) a = 8'h21;
      model_op(st, sz, 1'b0, a, 32'($urandom), el, ee, er, ew);
      run_op(st, sz, 1'b0, a, 32'($urandom), gl, ge, gr, gw, wa, wdt);
    end
    n_cmp++;
    if (LoadCnt !== 32'd3) begin n_fail++; $display("FAIL perf_load got=%0d exp=3", LoadCnt); end
    n_cmp++;
    if (StoreCnt !== 32'd2) begin n_fail++; $display("FAIL perf_store got=%0d exp=2", StoreCnt); end
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0; ref_rdata = 32'h0;
    n_cmp++;
    if ({LoadCnt, StoreCnt} !== 64'h0) begin
      n_fail++; $display("FAIL perf_reset got=%h exp=0", {LoadCnt, StoreCnt});
    end
  endtask
`endif

  task automatic test_word_store_load();
    int el, gl, ew, gw; bit ee, ge; logic [31:0] er, gr, wdt; logic [5:0] wa;
    model_op(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, el, ee, er, ew);
    run_op(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, gl, ge, gr, gw, wa, wdt);
    n_cmp++;
    if (gl !== 2 || gw !== 1 || wa !== 6'd4 || wdt !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_store lat=%0d we=%0d addr=%0d d=%h exp lat=2 we=1 addr=4 d=deadbeef", gl, gw, wa, wdt);
    end
    model_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, el, ee, er, ew);
    run_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, gl, ge, gr, gw, wa, wdt);
    n_cmp++;
    if (gl !== 2 || gr !== 32'hDEADBEEF || ge !== 1'b0 || gw !== 0) begin
      n_fail++;
      $display("FAIL word_load lat=%0d rd=%h err=%b we=%0d exp lat=2 rd=deadbeef err=0 we=0", gl, gr, ge, gw);
    end
  endtask

  task automatic test_byte_rmw();
    int el, gl, ew, gw; bit ee, ge; logic [31:0] er, gr, wdt; logic [5:0] wa;
    model_op(1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344, el, ee, er, ew);
    run_op(1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344, gl, ge, gr, gw, wa, wdt);
    model_op(1'b1, 2'b00, 1'b0, 8'h12, 32'h5A5A5AAA, el, ee, er, ew);
    run_op(1'b1, 2'b00, 1'b0, 8'h12, 32'h5A5A5AAA, gl, ge, gr, gw, wa, wdt);
    n_cmp++;
    if (gl !== 3 || gw !== 1 || wdt !== 32'h11AA3344) begin
      n_fail++;
      $display("FAIL byte_rmw lat=%0d we=%0d d=%h exp lat=3 we=1 d=11aa3344", gl, gw, wdt);
    end
    n_cmp++;
    if (ram[4] !== 32'h11AA3344 || ref_mem[4] !== 32'h11AA3344) begin
      n_fail++; $display("FAIL byte_rmw_mem got=%h exp=11aa3344", ram[4]);
    end
  endtask

  task automatic test_extend();
    int el, gl, ew, gw; bit ee, ge; logic [31:0] er, gr, wdt; logic [5:0] wa;
    logic [7:0]  addrs [5] = '{8'h12, 8'h12, 8'h12, 8'h10, 8'h13};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    bit          sgns  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exps  [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'h000011AA, 32'h00003344, 32'h00000011};
    for (int i = 0; i < 5; i++) begin
      model_op(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, el, ee, er, ew);
      run_op(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, gl, ge, gr, gw, wa, wdt);
      n_cmp++;
      if (gr !== exps[i] || er !== exps[i] || gl !== el) begin
        n_fail++; $display("FAIL extend_%0d rd=%h lat=%0d exp rd=%h lat=%0d", i, gr, gl, exps[i], el);
      end
    end
  endtask

  task automatic test_misaligned();
    int el, gl, ew, gw; bit ee, ge; logic [31:0] er, gr, wdt; logic [5:0] wa;
    bit          sts   [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
    logic [7:0]  addrs [3] = '{8'h11, 8'h13, 8'h10};
    for (int i = 0; i < 3; i++) begin
      model_op(sts[i], sizes[i], 1'b0, addrs[i], 32'hCAFEF00D, el, ee, er, ew);
      run_op(sts[i], sizes[i], 1'b0, addrs[i], 32'hCAFEF00D, gl, ge, gr, gw, wa, wdt);
      n_cmp++;
      if (gl !== 1 || ge !== 1'b1 || gw !== 0 || gr !== er || ram[4] !== 32'h11AA3344) begin
        n_fail++;
        $display("FAIL misaligned_%0d lat=%0d err=%b we=%0d rd=%h mem=%h exp lat=1 err=1 we=0 rd=%h mem=11aa3344",
                 i, gl, ge, gw, gr, ram[4], er);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int el, ew, dcnt, wcnt; bit ee; logic [31:0] er;
    model_op(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, el, ee, er, ew);
    @(negedge Clk);
    Req = 1'b1; IsStore = 1'b0; Size = 2'b10; Signed = 1'b0; ByteAddr = 8'h20;
    @(posedge Clk);
    #1;
    IsStore = 1'b1; ByteAddr = 8'h24; WData = $urandom;
    dcnt = 0; wcnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (Done) dcnt++;
      if (MemWE) wcnt++;
      if (k == 1) begin
        @(posedge Clk);
        #1 Req = 1'b0;
      end
    end
    n_cmp++;
    if (dcnt !== 1 || wcnt !== 0 || RData !== er || ram[9] !== ref_mem[9]) begin
      n_fail++;
      $display("FAIL busy_ignore dones=%0d we=%0d rd=%h exp dones=1 we=0 rd=%h", dcnt, wcnt, RData, er);
    end
  endtask

  task automatic test_back_to_back();
    int dcnt, first, last; bit bad_rd; logic [7:0] a;
    a = 8'($urandom) & 8'hFC;
    ref_rdata = ref_mem[a / 4];
    @(negedge Clk);
    Req = 1'b1; IsStore = 1'b0; Size = 2'b10; Signed = 1'b0; ByteAddr = a;
    dcnt = 0; first = -1; last = -1; bad_rd = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge Clk);
      if (k == 9) #1 Req = 1'b0;
      @(negedge Clk);
      if (Done) begin
        dcnt++;
        if (first < 0) first = k;
        last = k;
        if (RData !== ref_rdata) bad_rd = 1'b1;
      end
    end
    n_cmp++;
    if (dcnt !== 3 || first !== 2 || last !== 8 || bad_rd) begin
      n_fail++;
      $display("FAIL back_to_back dones=%0d first=%0d last=%0d bad_rd=%b exp dones=3 first=2 last=8 bad_rd=0",
               dcnt, first, last, bad_rd);
    end
  endtask

  task automatic test_midop_reset();
    int wcnt;
    @(negedge Clk);
    Req = 1'b1; IsStore = 1'b1; Size = 2'b00; Signed = 1'b0; ByteAddr = 8'h31; WData = $urandom;
    @(posedge Clk);
    #1;
    Req = 1'b0; Rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({Busy, Done, Err, MemWE, RData, MemAddr, MemD} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset got=%h exp=0", {Busy, Done, Err, MemWE, RData, MemAddr, MemD});
    end
    Rst = 1'b0;
    ref_rdata = 32'h0;
    wcnt = 0;
    repeat (4) begin
      @(negedge Clk);
      if (MemWE) wcnt++;
    end
    n_cmp++;
    if (wcnt !== 0 || ram[12] !== ref_mem[12]) begin
      n_fail++; $display("FAIL midop_nowrite we=%0d mem=%h exp we=0 mem=%h", wcnt, ram[12], ref_mem[12]);
    end
  endtask

  task automatic test_random();
    int el, gl, ew, gw; bit ee, ge; logic [31:0] er, gr, wdt; logic [5:0] wa;
    bit st, sg; logic [1:0] sz; logic [7:0] a; logic [31:0] wd;
    for (int i = 0; i < 80; i++) begin
      st = $urandom_range(0, 1); sg = $urandom_range(0, 1);
      sz = 2'($urandom_range(0, 3)); a = 8'($urandom); wd = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'b10) a[1:0] = 2'b00;
        if (sz == 2'b01) a[0] = 1'b0;
      end
      model_op(st, sz, sg, a, wd, el, ee, er, ew);
      run_op(st, sz, sg, a, wd, gl, ge, gr, gw, wa, wdt);
      n_cmp++;
      if (gl !== el || ge !== ee || gr !== er || gw !== ew) begin
        n_fail++;
        $display("FAIL rand_%0d st=%b sz=%0d a=%h lat=%0d err=%b rd=%h we=%0d exp lat=%0d err=%b rd=%h we=%0d",
                 i, st, sz, a, gl, ge, gr, gw, el, ee, er, ew);
      end
      n_cmp++;
      if (ram[a / 4] !== ref_mem[a / 4] || (gw == 1 && wa !== a[7:2])) begin
        n_fail++;
        $display("FAIL rand_mem_%0d a=%h mem=%h we_addr=%0d exp mem=%h", i, a, ram[a / 4], wa, ref_mem[a / 4]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_rdata = 32'h0;
    test_reset();
`ifdef MEM_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_word_store_load();
    test_byte_rmw();
    test_extend();
    test_misaligned();
    test_busy_ignore();
    test_back_to_back();
    test_midop_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store controller directly upstream of the 64x32 data memory (async-read distributed RAM; synchronous write on WE).
- Accepts byte-addressed load/store requests from the CPU datapath and drives the memory's WE/Addr/Data.
- Sub-word stores are done as read-modify-write; load data is sign- or zero-extended and returned with a Done pulse.

Parameters:
- ADDR_W, 6, word-address width to memory; byte address is ADDR_W+2 bits.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req  in  1  request strobe; sampled only in IDLE.
- IsStore  in  1  1=store, 0=load.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- Signed  in  1  loads only: 1 sign-extend, 0 zero-extend.
- ByteAddr  in  ADDR_W+2  byte address.
- WData  in  32  store data; only the low byte/half is used for sub-word stores.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done; 1 = misaligned/reserved, no memory write.
- RData  out  32  load result; held until the next load's Done.
- MemWE  out  1  memory write enable.
- MemAddr  out  ADDR_W  word address, ByteAddr[ADDR_W+1:2].
- MemD  out  32  memory write data.
- MemSPO  in  32  memory read data (combinational from MemAddr).

Behaviour:
- Reset values: state=IDLE; Busy=0, Done=0, Err=0, RData=0, MemWE=0, MemAddr=0, MemD=0. Reset mid-operation aborts with no write; MemWE is 0 the cycle after reset.
- Latching: Req in IDLE latches IsStore, Size, Signed, ByteAddr and WData. Req outside IDLE is ignored, not queued.
- Byte lanes: little-endian, lane = ByteAddr[1:0].
- Misaligned: half with ByteAddr[0]=1, word with ByteAddr[1:0]!=0, or Size=11.
- States:
  - IDLE: on Req, go to ERR if misaligned, else to ACCESS.
  - ERR: Done=1, Err=1, MemWE=0, RData unchanged; go to IDLE.
  - ACCESS: MemAddr=latched word address.
    - Load: RData <= extract(MemSPO, lane, Size, Signed); go to DONE.
    - Word store: MemWE=1, MemD=WData; go to DONE.
    - Sub-word store: capture MemSPO into merge register; go to WRITE.
  - WRITE: MemWE=1, MemD = merge register with the target byte/half lane replaced by WData[7:0]/[15:0]; go to DONE.
  - DONE: Done=1, Err=0; go to IDLE.
- Latency (Req accepted at edge t):
  - Load or word store: Done high in cycle t+2.
  - Sub-word store: Done high in cycle t+3.
  - Error: Done+Err high in cycle t+1.
  - Back-to-back: next Req is accepted in the cycle after Done.
- Extraction:
  - byte = MemSPO[8*lane+7:8*lane];
  - half = MemSPO[16*ByteAddr[1]+15 : 16*ByteAddr[1]];
  - extend to 32 bits per Signed.
- Memory port is a registered output: MemWE high for exactly one cycle per store and never on load or error paths. MemAddr holds the latched value from ACCESS until the next request.
- Address wrap: no out-of-range case; every ADDR_W+2-bit address maps to a word.

Optional Feature:
- MEM_PERF_CNT_EN defined: adds outputs LoadCnt[31:0] and StoreCnt[31:0].
  - Each increments on Done of a successful load or store; errors are not counted.
  - Both wrap modulo 2^32 and clear on Rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Word store then load: store WData=32'hDEADBEEF at ByteAddr=8'h10, then word load at 8'h10 -> MemWE pulse with MemAddr=4, MemD=DEADBEEF; RData=32'hDEADBEEF at t+2.
- Byte RMW: memory word 4 = 32'h11223344; store byte 8'hAA at 8'h12 -> WRITE cycle MemD=32'h11AA3344; Done at t+3; memory holds 11AA3344.
- Sign/zero extend: word 4 = 32'h11AA3344; byte load at 8'h12 Signed=1 -> RData=32'hFFFFFFAA; Signed=0 -> 32'h000000AA. Half load at 8'h12 Signed=1 -> 32'h000011AA.
- Misaligned: word load at 8'h11 -> Done=1, Err=1 at t+1; RData unchanged; no MemWE. Half store at 8'h13 -> same response, memory unchanged.
- Req during Busy and mid-op reset: second Req during ACCESS is ignored (single Done). Rst asserted in ACCESS of a sub-word store -> no MemWE, all outputs 0 next cycle.
- MEM_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned -> LoadCnt=3, StoreCnt=2; Rst -> both 0.
